// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int unsigned NREQ_DEFAULT      = 4;
    localparam int unsigned BURST_MAX_DEFAULT = 8;

endpackage

// File: rtl/fifo_wr_rr_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after rr_ptr, circularly.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            any_req,
    output logic [ID_W-1:0] pick
);

    logic [NREQ-1:0] rot;
    logic [ID_W-1:0] start;
    logic [ID_W-1:0] offset;

    // Rotate so the search start lands on bit 0, priority-encode, then rotate back.
    always_comb begin
        start  = (rr_ptr == ID_W'(NREQ - 1)) ? '0 : rr_ptr + ID_W'(1);
        rot    = '0;
        offset = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rot[i] = req[ID_W'((32'(start) + 32'(i)) % NREQ)];
        end
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        any_req = |req;
        pick    = ID_W'((32'(start) + 32'(offset)) % NREQ);
    end

endmodule

// File: rtl/fifo_wr_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ packet producers.
// A grant is held for a whole packet or at most BURST_MAX beats, then priority rotates.
module fifo_wr_rr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned NREQ      = NREQ_DEFAULT,
    parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT,
    parameter int unsigned ID_W      = $clog2(NREQ),
    parameter int unsigned CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*DATA_W-1:0] i_req_data,
    input  logic [NREQ-1:0]        i_req_last,
    output logic [NREQ-1:0]        o_req_ready,
    output logic                   o_fifo_wren,
    output logic [DATA_W-1:0]      o_fifo_wrdata,
    input  logic                   i_fifo_full,
    output logic [ID_W-1:0]        o_grant_id,
    output logic                   o_busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              beat;
    logic              rel;
    logic [DATA_W-1:0] chan_data [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req     (i_req_valid),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .pick    (pick)
    );

    // Beat qualification and release condition for the granted producer.
    always_comb begin
        for (int k = 0; k < int'(NREQ); k++) begin
            chan_data[k] = i_req_data[k*DATA_W +: DATA_W];
        end
        beat = (state == LOCK) && i_req_valid[grant_id] && !i_fifo_full;
        rel  = beat && (i_req_last[grant_id] ||
                        ((beat_cnt + CNT_W'(1)) == CNT_W'(BURST_MAX)));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE grants on any request, LOCK releases on last beat or burst cap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOCK;
            LOCK:    if (rel)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready/wren straight from the grant and full flag, data from the granted lane.
    always_comb begin
        o_req_ready   = '0;
        o_fifo_wren   = 1'b0;
        o_fifo_wrdata = chan_data[grant_id];
        if (state == LOCK) begin
            o_req_ready[grant_id] = !i_fifo_full;
            o_fifo_wren           = beat;
        end
    end

    assign o_busy     = (state == LOCK);
    assign o_grant_id = grant_id;

    // Grant index, beat counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= ID_W'(NREQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else if ((state == IDLE) && any_req) begin
            grant_id <= pick;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (rel) begin
                rr_ptr <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
// Self-checking bench: cycle model of the arbitration rules plus directed packet scenarios.
module tb_fifo_wr_rr_arb;

    localparam int unsigned DATA_W    = 4;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned BURST_MAX = 8;
    localparam int unsigned ID_W      = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_wren;
    logic [DATA_W-1:0]      fifo_wrdata;
    logic                   fifo_full;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    fifo_wr_rr_arb #(
        .DATA_W    (DATA_W),
        .NREQ      (NREQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_fifo_wren   (fifo_wren),
        .o_fifo_wrdata (fifo_wrdata),
        .i_fifo_full   (fifo_full),
        .o_grant_id    (grant_id),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Per-producer beat queues (fixed arrays with head/tail indices).
    typedef struct packed {
        logic [3:0] data;
        logic       last;
        logic [3:0] gap;
    } beat_t;

    beat_t bufs [NREQ][32];
    int    head [NREQ];
    int    tail [NREQ];

    // Write log captured from the FIFO port.
    int log_data [256];
    int log_id   [256];
    int log_cyc  [256];
    int nlog = 0;

    // Behavioural model state.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_beats = 0;
    int m_last  = NREQ - 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int d, input bit l, input int g);
        bufs[k][tail[k]] = '{data: 4'(d), last: l, gap: 4'(g)};
        tail[k]++;
    endtask

    task automatic flush();
        for (int k = 0; k < int'(NREQ); k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
    endtask

    task automatic wait_log(input int n, input int limit);
        int t;
        t = 0;
        while (nlog < n && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (nlog < n) begin
            errors++;
            $display("FAIL wait_log: got %0d writes expected %0d", nlog, n);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input int id, input int d, input int dcyc);
        chk({tag, "_id"}, log_id[idx], id);
        chk({tag, "_data"}, log_data[idx], d);
        if (dcyc >= 0) chk({tag, "_gap"}, log_cyc[idx] - log_cyc[idx-1], dcyc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 flush();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Producer driver: retire handshaken beats, then present head beat (honouring gaps).
    initial begin
        logic [NREQ-1:0] hs;
        flush();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int k = 0; k < int'(NREQ); k++) begin
                if (hs[k] && head[k] != tail[k]) head[k]++;
                if (head[k] == tail[k]) begin
                    req_valid[k] = 1'b0;
                    req_last[k]  = 1'b0;
                end else if (bufs[k][head[k]].gap != 4'd0) begin
                    req_valid[k] = 1'b0;
                    bufs[k][head[k]].gap = bufs[k][head[k]].gap - 4'd1;
                end else begin
                    req_valid[k]               = 1'b1;
                    req_data[k*DATA_W +: DATA_W] = bufs[k][head[k]].data;
                    req_last[k]                = bufs[k][head[k]].last;
                end
            end
        end
    end

    // Compare process: check outputs against the model each cycle, log writes, advance model.
    initial begin
        forever begin
            logic [NREQ-1:0]   e_ready;
            logic              e_wren;
            logic [DATA_W-1:0] e_data;
            @(negedge clk);
            cyc++;
            e_ready = '0;
            e_wren  = 1'b0;
            e_data  = req_data[m_owner*DATA_W +: DATA_W];
            if (!rst && m_busy && !fifo_full) e_ready[m_owner] = 1'b1;
            if (!rst && m_busy && !fifo_full && req_valid[m_owner]) e_wren = 1'b1;
            chk("cmp_ready", int'(req_ready), int'(e_ready));
            chk("cmp_wren", int'(fifo_wren), int'(e_wren));
            chk("cmp_busy", int'(busy), rst ? 0 : int'(m_busy));
            chk("cmp_grant", int'(grant_id), rst ? 0 : m_owner);
            if (e_wren) chk("cmp_wrdata", int'(fifo_wrdata), int'(e_data));
            if (fifo_wren && nlog < 256) begin
                log_data[nlog] = int'(fifo_wrdata);
                log_id[nlog]   = int'(grant_id);
                log_cyc[nlog]  = cyc;
                nlog++;
            end
            if (rst) begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_beats = 0;
                m_last  = NREQ - 1;
            end else if (!m_busy) begin
                for (int s = 1; s <= int'(NREQ); s++) begin
                    int c;
                    c = (m_last + s) % NREQ;
                    if (!m_busy && req_valid[c]) begin
                        m_busy  = 1'b1;
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else if (e_wren) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == int'(BURST_MAX)) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        int base;
        int n0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_wren", int'(fifo_wren), 0);
        chk("rst_grant", int'(grant_id), 0);

        // Single 3-beat packet from producer 2.
        base = nlog;
        n0   = cyc;
        push(2, 'hA, 1'b0, 0);
        push(2, 'hB, 1'b0, 0);
        push(2, 'hC, 1'b1, 0);
        wait_log(base + 3, 20);
        chk("t1_latency", log_cyc[base] - n0, 2);
        chk_log("t1_b0", base, 2, 'hA, -1);
        chk_log("t1_b1", base + 1, 2, 'hB, 1);
        chk_log("t1_b2", base + 2, 2, 'hC, 1);
        @(negedge clk);
        #1;
        chk("t1_busy_after", int'(busy), 0);

        // Round-robin across all producers with single-beat packets.
        do_reset();
        @(negedge clk);
        #1;
        base = nlog;
        push(0, 1, 1'b1, 0);
        push(0, 5, 1'b1, 0);
        push(1, 2, 1'b1, 0);
        push(2, 3, 1'b1, 0);
        push(3, 4, 1'b1, 0);
        wait_log(base + 5, 40);
        chk_log("t2_w0", base, 0, 1, -1);
        chk_log("t2_w1", base + 1, 1, 2, 2);
        chk_log("t2_w2", base + 2, 2, 3, 2);
        chk_log("t2_w3", base + 3, 3, 4, 2);
        chk_log("t2_w4", base + 4, 0, 5, 2);

        // Burst cap: producer 1 offers 12 beats without last, producer 3 waiting.
        do_reset();
        @(negedge clk);
        #1;
        base = nlog;
        for (int i = 0; i < 12; i++) push(1, i, 1'b0, 0);
        push(3, 'hF, 1'b1, 0);
        wait_log(base + 13, 60);
        for (int i = 0; i < 8; i++) chk_log("t3_burst", base + i, 1, i, (i == 0) ? -1 : 1);
        chk_log("t3_p3", base + 8, 3, 'hF, 2);
        for (int i = 0; i < 4; i++) chk_log("t3_rest", base + 9 + i, 1, 8 + i, (i == 0) ? 2 : 1);
        repeat (3) @(negedge clk);
        #1;
        chk("t3_lock_held", int'(busy), 1);

        // Full stall of 5 cycles after the first beat of a 4-beat packet.
        do_reset();
        @(negedge clk);
        #1;
        base = nlog;
        push(2, 1, 1'b0, 0);
        push(2, 2, 1'b0, 0);
        push(2, 3, 1'b0, 0);
        push(2, 4, 1'b1, 0);
        wait_log(base + 1, 20);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_log(base + 4, 20);
        chk_log("t4_b0", base, 2, 1, -1);
        chk_log("t4_b1", base + 1, 2, 2, 6);
        chk_log("t4_b2", base + 2, 2, 3, 1);
        chk_log("t4_b3", base + 3, 2, 4, 1);

        // Valid gap mid-packet on producer 0 while producer 1 waits.
        do_reset();
        @(negedge clk);
        #1;
        base = nlog;
        push(0, 5, 1'b0, 0);
        push(0, 6, 1'b0, 0);
        push(0, 7, 1'b0, 3);
        push(0, 8, 1'b1, 0);
        push(1, 9, 1'b1, 0);
        wait_log(base + 5, 40);
        chk_log("t5_b0", base, 0, 5, -1);
        chk_log("t5_b1", base + 1, 0, 6, 1);
        chk_log("t5_b2", base + 2, 0, 7, 4);
        chk_log("t5_b3", base + 3, 0, 8, 1);
        chk_log("t5_p1", base + 4, 1, 9, 2);

        // Asynchronous reset while beat 3 is on the port.
        do_reset();
        @(negedge clk);
        #1;
        base = nlog;
        for (int i = 1; i <= 5; i++) push(0, i, (i == 5), 0);
        wait_log(base + 3, 20);
        chk("t6_pre_wren", int'(fifo_wren), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_wren", int'(fifo_wren), 0);
        chk("t6_async_ready", int'(req_ready), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_grant", int'(grant_id), 0);
        @(posedge clk);
        #2 flush();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        base = nlog;
        push(3, 'hD, 1'b1, 0);
        push(0, 'hE, 1'b1, 0);
        push(1, 7, 1'b1, 0);
        wait_log(base + 3, 30);
        chk_log("t6_w0", base, 0, 'hE, -1);
        chk_log("t6_w1", base + 1, 1, 7, 2);
        chk_log("t6_w2", base + 2, 3, 'hD, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
